sdram_port_scheduler: RTL



---
 rtl/sdram_port_scheduler_pkg.sv | 33 +++
 rtl/sdram_rr_pick2.sv | 43 ++++
 rtl/sdram_port_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sdram_port_scheduler_pkg.sv
// Shared definitions for the three-port SDRAM scheduler: call encodings,
// port ids, FSM states and parameter defaults.
package sdram_port_scheduler_pkg;

    localparam int ADDR_W_DEF       = 24;
    localparam int DATA_W_DEF       = 16;
    localparam int P0_BURST_MAX_DEF = 8;
    localparam int TIMEOUT_DEF      = 4095;

    // Width of the GRANT watchdog counter.
    localparam int WD_W = 12;

    // Call/done encodings towards the SDRAM base: bit 1 = write, bit 0 = read.
    localparam logic [1:0] CALL_NONE = 2'b00;
    localparam logic [1:0] CALL_RD   = 2'b01;
    localparam logic [1:0] CALL_WR   = 2'b10;

    // Read word returned to the display when the watchdog aborts an access.
    localparam logic [15:0] ABORT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        PORT_P0 = 2'd0,  // TFT refresh reader
        PORT_P1 = 2'd1,  // pulse-counter logger
        PORT_P2 = 2'd2   // draw writer
    } port_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/sdram_rr_pick2.sv
// Two-request round-robin picker for the write ports. The pointer names the
// preferred port on a tie and moves away from whichever port was just served.
module sdram_rr_pick2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,   // [0] = P1, [1] = P2
    input  logic       take_i,  // the current pick is being granted this cycle
    output logic [1:0] gnt_o    // one-hot pick, valid whenever req_i != 0
);

    logic ptr_q;  // 0: P1 preferred, 1: P2 preferred
    logic ptr_d;

    // Pick a single requester; the pointer only matters when both ask.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    // Next pointer: the port just served loses the next tie.
    always_comb begin
        ptr_d = ptr_q;
        if (take_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    // Pointer register, P1 preferred out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares the SDRAM base controller between the TFT reader (P0, strict
// priority with a burst limit), and two round-robin write ports (P1, P2).
// A watchdog aborts a GRANT that never sees its done bit.
module sdram_port_scheduler
    import sdram_port_scheduler_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int P0_BURST_MAX = P0_BURST_MAX_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              iP0_Rd_Req,
    input  logic [ADDR_W-1:0] iP0_Rd_Addr,
    output logic              oP0_Rd_Done,
    output logic [DATA_W-1:0] oP0_Rd_Data,
    input  logic              iP1_Wr_Req,
    input  logic [ADDR_W-1:0] iP1_Wr_Addr,
    input  logic [DATA_W-1:0] iP1_Wr_Data,
    output logic              oP1_Wr_Done,
    input  logic              iP2_Wr_Req,
    input  logic [ADDR_W-1:0] iP2_Wr_Addr,
    input  logic [DATA_W-1:0] iP2_Wr_Data,
    output logic              oP2_Wr_Done,
    output logic [1:0]        oMem_Call,
    output logic [ADDR_W-1:0] oMem_Addr,
    output logic [DATA_W-1:0] oMem_Data,
    input  logic [DATA_W-1:0] iMem_Data,
    input  logic [1:0]        iMem_Done,
    output logic              oBusy,
    output logic              oErr
);

    localparam int                  STREAK_W   = $clog2(P0_BURST_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(P0_BURST_MAX);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0]   ABORT_WORD = DATA_W'(ABORT_DATA);

    state_e              state_q;
    port_e               port_q;
    logic [1:0]          call_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                p0_done_q;
    logic                p1_done_q;
    logic                p2_done_q;
    logic                busy_q;
    logic                err_q;
    logic [STREAK_W-1:0] streak_q;
    logic [WD_W-1:0]     wd_q;

    logic [1:0] wr_req;
    logic [1:0] rr_gnt;
    logic       any_wr;
    logic       p0_wins;
    logic       grant_now;
    logic       wr_take;
    logic       done_match;
    logic       wd_expired;
    logic       grant_end;

    assign wr_req     = {iP2_Wr_Req, iP1_Wr_Req};
    assign any_wr     = |wr_req;
    // P0 yields only once its streak is used up and a writer is actually waiting.
    assign p0_wins    = iP0_Rd_Req && ((streak_q < STREAK_MAX) || !any_wr);
    assign grant_now  = (state_q == ST_IDLE) && en && (iP0_Rd_Req || any_wr);
    assign wr_take    = grant_now && !p0_wins;
    // Call and done share the same bit layout, so only the matching bit counts.
    assign done_match = |(iMem_Done & call_q);
    assign wd_expired = (wd_q == WD_LAST);
    assign grant_end  = (state_q == ST_GRANT) && (done_match || wd_expired);

    sdram_rr_pick2 u_rr_pick2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (wr_req),
        .take_i (wr_take),
        .gnt_o  (rr_gnt)
    );

    // Scheduler FSM with all outward-facing signals registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_P0;
            call_q    <= CALL_NONE;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            p2_done_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            streak_q  <= '0;
            wd_q      <= '0;
        end else begin
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            p2_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!any_wr) begin
                        streak_q <= '0;
                    end
                    if (grant_now) begin
                        state_q <= ST_GRANT;
                        busy_q  <= 1'b1;
                        wd_q    <= '0;
                        if (p0_wins) begin
                            port_q <= PORT_P0;
                            call_q <= CALL_RD;
                            addr_q <= iP0_Rd_Addr;
                            data_q <= '0;
                            if (any_wr && (streak_q != STREAK_MAX)) begin
                                streak_q <= streak_q + 1'b1;
                            end
                        end else if (rr_gnt[0]) begin
                            port_q   <= PORT_P1;
                            call_q   <= CALL_WR;
                            addr_q   <= iP1_Wr_Addr;
                            data_q   <= iP1_Wr_Data;
                            streak_q <= '0;
                        end else begin
                            port_q   <= PORT_P2;
                            call_q   <= CALL_WR;
                            addr_q   <= iP2_Wr_Addr;
                            data_q   <= iP2_Wr_Data;
                            streak_q <= '0;
                        end
                    end
                end
                ST_GRANT: begin
                    if (grant_end) begin
                        // A real done wins over a watchdog expiry in the same cycle.
                        state_q   <= ST_RELEASE;
                        call_q    <= CALL_NONE;
                        p0_done_q <= (port_q == PORT_P0);
                        p1_done_q <= (port_q == PORT_P1);
                        p2_done_q <= (port_q == PORT_P2);
                        if (port_q == PORT_P0) begin
                            rd_data_q <= done_match ? iMem_Data : ABORT_WORD;
                        end
                        if (!done_match) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    call_q  <= CALL_NONE;
                end
            endcase
        end
    end

    assign oMem_Call   = call_q;
    assign oMem_Addr   = addr_q;
    assign oMem_Data   = data_q;
    assign oP0_Rd_Data = rd_data_q;
    assign oP0_Rd_Done = p0_done_q;
    assign oP1_Wr_Done = p1_done_q;
    assign oP2_Wr_Done = p2_done_q;
    assign oBusy       = busy_q;
    assign oErr        = err_q;

endmodule
